// File: rtl/boolean_sweep_pkg.sv
// Shared types and constants for the boolean truth-table sweeper.
// Holds the FSM state encoding and the vector, index and count widths.
package boolean_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int VEC_N = 16;
  localparam int IDX_W = 4;
  localparam int CNT_W = 5;
  localparam int NUM_Y = 5;

endpackage

// File: rtl/boolean_tt_sweeper.sv
// Drives A..D through all 16 vectors and captures Y1..Y5 into per-output truth tables.
// Each vector is held for SETTLE+1 cycles. Sampling happens on the last cycle of the hold.
//
// state | meaning
// IDLE  | waiting for start; A..D hold the last vector driven
// DRIVE | holding vector idx, then sampling Y when the settle count reaches SETTLE
// DONE  | one-cycle completion pulse; results are final
module boolean_tt_sweeper
  import boolean_sweep_pkg::*;
#(
  parameter int SETTLE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              A,
  output logic              B,
  output logic              C,
  output logic              D,
  input  logic              Y1,
  input  logic              Y2,
  input  logic              Y3,
  input  logic              Y4,
  input  logic              Y5,
  output logic              busy,
  output logic              done,
  output logic [VEC_N-1:0]  TT1,
  output logic [VEC_N-1:0]  TT2,
  output logic [VEC_N-1:0]  TT3,
  output logic [VEC_N-1:0]  TT4,
  output logic [VEC_N-1:0]  TT5,
  output logic [CNT_W-1:0]  ONES1,
  output logic [CNT_W-1:0]  ONES2,
  output logic [CNT_W-1:0]  ONES3,
  output logic [CNT_W-1:0]  ONES4,
  output logic [CNT_W-1:0]  ONES5
);

  localparam logic [1:0] SETTLE_C = 2'(SETTLE);

  state_t              state, state_n;
  logic [IDX_W-1:0]    idx;
  logic [1:0]          settle_cnt;
  logic [VEC_N-1:0]    tt   [NUM_Y];
  logic [CNT_W-1:0]    ones [NUM_Y];
  logic [NUM_Y-1:0]    y;
  logic                sample;
  logic                last_vec;

  assign y        = {Y5, Y4, Y3, Y2, Y1};
  assign sample   = (state == DRIVE) && (settle_cnt == SETTLE_C);
  assign last_vec = (idx == IDX_W'(VEC_N - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = DRIVE;
      DRIVE:   if (sample && last_vec) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // idx doubles as the stimulus register, so it stays at 15 after a sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      settle_cnt <= '0;
      for (int k = 0; k < NUM_Y; k++) begin
        tt[k]   <= '0;
        ones[k] <= '0;
      end
    end else if (state == IDLE && start) begin
      idx        <= '0;
      settle_cnt <= '0;
      for (int k = 0; k < NUM_Y; k++) begin
        tt[k]   <= '0;
        ones[k] <= '0;
      end
    end else if (state == DRIVE) begin
      if (sample) begin
        settle_cnt <= '0;
        if (!last_vec) idx <= idx + 1'b1;
        for (int k = 0; k < NUM_Y; k++) begin
          tt[k][idx] <= y[k];
          ones[k]    <= ones[k] + CNT_W'(y[k]);
        end
      end else begin
        settle_cnt <= settle_cnt + 1'b1;
      end
    end
  end

  assign {A, B, C, D} = idx;
  assign busy  = (state == DRIVE);
  assign done  = (state == DONE);
  assign TT1   = tt[0];
  assign TT2   = tt[1];
  assign TT3   = tt[2];
  assign TT4   = tt[3];
  assign TT5   = tt[4];
  assign ONES1 = ones[0];
  assign ONES2 = ones[1];
  assign ONES3 = ones[2];
  assign ONES4 = ones[3];
  assign ONES5 = ones[4];

endmodule

// File: tb/tb_boolean_tt_sweeper.sv
// Bench for boolean_tt_sweeper: two instances (SETTLE=0 and SETTLE=2) each driving a table-lookup expression block.
// Expected tables, ones counts and edge timing come from the sweep rules, independent of the RTL structure.
module tb_boolean_tt_sweeper;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0;
  logic start2 = 1'b0;
  int   cyc_cnt = 0;
  int   n_checks = 0;
  int   n_err = 0;

  logic [15:0] tbl [5];

  logic a0, b0, c0, d0, busy0, done0;
  logic a2, b2, c2, d2, busy2, done2;
  logic [4:0]  y0, y2;
  logic [15:0] tt0 [5];
  logic [15:0] tt2 [5];
  logic [4:0]  ones0 [5];
  logic [4:0]  ones2 [5];
  logic [3:0]  v0, v2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Expression block stand-in: each output is a lookup into its truth table.
  assign v0 = {a0, b0, c0, d0};
  assign v2 = {a2, b2, c2, d2};
  always_comb begin
    y0 = '0;
    y2 = '0;
    for (int k = 0; k < 5; k++) begin
      y0[k] = tbl[k][v0];
      y2[k] = tbl[k][v2];
    end
  end

  boolean_tt_sweeper #(.SETTLE(0)) u_s0 (
    .clk(clk), .rst(rst), .start(start0),
    .A(a0), .B(b0), .C(c0), .D(d0),
    .Y1(y0[0]), .Y2(y0[1]), .Y3(y0[2]), .Y4(y0[3]), .Y5(y0[4]),
    .busy(busy0), .done(done0),
    .TT1(tt0[0]), .TT2(tt0[1]), .TT3(tt0[2]), .TT4(tt0[3]), .TT5(tt0[4]),
    .ONES1(ones0[0]), .ONES2(ones0[1]), .ONES3(ones0[2]), .ONES4(ones0[3]), .ONES5(ones0[4])
  );

  boolean_tt_sweeper #(.SETTLE(2)) u_s2 (
    .clk(clk), .rst(rst), .start(start2),
    .A(a2), .B(b2), .C(c2), .D(d2),
    .Y1(y2[0]), .Y2(y2[1]), .Y3(y2[2]), .Y4(y2[3]), .Y5(y2[4]),
    .busy(busy2), .done(done2),
    .TT1(tt2[0]), .TT2(tt2[1]), .TT3(tt2[2]), .TT4(tt2[3]), .TT5(tt2[4]),
    .ONES1(ones2[0]), .ONES2(ones2[1]), .ONES3(ones2[2]), .ONES4(ones2[3]), .ONES5(ones2[4])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int s, input logic v);
    if (s == 0) start0 = v;
    else        start2 = v;
  endtask

  function automatic logic [3:0] get_vec(input int s);
    return (s == 0) ? v0 : v2;
  endfunction
  function automatic logic get_busy(input int s);
    return (s == 0) ? busy0 : busy2;
  endfunction
  function automatic logic get_done(input int s);
    return (s == 0) ? done0 : done2;
  endfunction
  function automatic logic [15:0] get_tt(input int s, input int k);
    return (s == 0) ? tt0[k] : tt2[k];
  endfunction
  function automatic logic [4:0] get_ones(input int s, input int k);
    return (s == 0) ? ones0[k] : ones2[k];
  endfunction

  task automatic check_results(input int s, input string tag);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("%s_s%0d_tt%0d", tag, s, k + 1), 32'(get_tt(s, k)), 32'(tbl[k]));
      check($sformatf("%s_s%0d_ones%0d", tag, s, k + 1), 32'(get_ones(s, k)), 32'($countones(tbl[k])));
    end
  endtask

  task automatic check_zero(input int s, input string tag);
    logic [15:0] tt_or;
    logic [4:0]  ones_or;
    tt_or = '0;
    ones_or = '0;
    for (int k = 0; k < 5; k++) begin
      tt_or   = tt_or | get_tt(s, k);
      ones_or = ones_or | get_ones(s, k);
    end
    check($sformatf("%s_s%0d_vec", tag, s), 32'(get_vec(s)), 0);
    check($sformatf("%s_s%0d_busy_done", tag, s), 32'({get_busy(s), get_done(s)}), 0);
    check($sformatf("%s_s%0d_tt", tag, s), 32'(tt_or), 0);
    check($sformatf("%s_s%0d_ones", tag, s), 32'(ones_or), 0);
  endtask

  // One sweep with timing checks; optional start re-pulses at sweep cycles 3 and 10.
  task automatic do_sweep(input int s, input bit repulse, input string tag);
    int  t, per, k, last_k;
    bit  seen;
    per = (s == 0) ? 1 : 3;
    last_k = 16 * per;
    seen = 0;
    @(negedge clk);
    set_start(s, 1'b1);
    t = cyc_cnt + 1;
    @(negedge clk);
    set_start(s, 1'b0);
    for (int n = 0; n < last_k + 4 && !seen; n++) begin
      k = cyc_cnt - t + 1;
      if (k <= last_k) begin
        check($sformatf("%s_busy_k%0d", tag, k), 32'(get_busy(s)), 1);
        check($sformatf("%s_vec_k%0d", tag, k), 32'(get_vec(s)), 32'((k - 1) / per));
      end else if (get_done(s)) begin
        seen = 1;
        check($sformatf("%s_done_edge", tag), 32'(k), 32'(last_k + 1));
        check($sformatf("%s_busy_at_done", tag), 32'(get_busy(s)), 0);
        check($sformatf("%s_vec_hold", tag), 32'(get_vec(s)), 15);
        check_results(s, tag);
      end
      if (!seen) begin
        set_start(s, repulse && (k == 3 || k == 10));
        @(negedge clk);
      end
    end
    set_start(s, 1'b0);
    if (!seen) check($sformatf("%s_done_timeout", tag), 0, 1);
    @(negedge clk);
    check($sformatf("%s_done_pulse", tag), 32'({get_done(s), get_busy(s)}), 0);
    check_results(s, {tag, "_hold"});
  endtask

  task automatic load_spec_tables();
    tbl[0] = 16'h0DD0;
    tbl[1] = 16'h0BBB;
    tbl[2] = 16'hFCC0;
    tbl[3] = 16'($urandom);
    tbl[4] = 16'($urandom);
  endtask

  initial begin
    int  ndone, last_done;
    bit  prev_busy;
    logic [15:0] tt_or;
    logic [4:0]  ones_or;

    load_spec_tables();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_zero(0, "reset");
    check_zero(2, "reset");
    rst = 1'b0;

    do_sweep(0, 1'b0, "basic0");
    do_sweep(2, 1'b0, "basic2");
    do_sweep(0, 1'b1, "repulse");

    // Reset during vector 7.
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (7) @(negedge clk);
    check("midrst_vec7", 32'(v0), 7);
    rst = 1'b1;
    @(negedge clk);
    check_zero(0, "midrst");
    rst = 1'b0;
    do_sweep(0, 1'b0, "after_rst");

    // Reset and start together: reset wins.
    @(negedge clk);
    rst = 1'b1;
    start0 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start0 = 1'b0;
    check_zero(0, "rst_start");

    // start held high: back-to-back sweeps.
    @(negedge clk);
    start0 = 1'b1;
    ndone = 0;
    last_done = 0;
    prev_busy = 1'b0;
    for (int n = 0; n < 120 && ndone < 3; n++) begin
      @(negedge clk);
      if (busy0 && !prev_busy) begin
        tt_or = '0;
        ones_or = '0;
        for (int k = 0; k < 5; k++) begin
          tt_or = tt_or | tt0[k];
          ones_or = ones_or | ones0[k];
        end
        check("held_clear", 32'({tt_or, 11'd0, ones_or}), 0);
      end
      if (done0) begin
        ndone++;
        if (ndone > 1) check("held_gap", 32'(cyc_cnt - last_done), 18);
        last_done = cyc_cnt;
        check_results(0, "held");
        if (ndone == 3) start0 = 1'b0;
      end
      prev_busy = busy0;
    end
    start0 = 1'b0;
    check("held_count", 32'(ndone), 3);
    repeat (3) @(negedge clk);
    check("held_stop", 32'(busy0), 0);

    // Constant expression outputs.
    for (int k = 0; k < 5; k++) tbl[k] = 16'hFFFF;
    do_sweep(0, 1'b0, "ones0");
    do_sweep(2, 1'b0, "ones2");
    for (int k = 0; k < 5; k++) tbl[k] = 16'h0000;
    do_sweep(0, 1'b0, "zeros0");
    do_sweep(2, 1'b0, "zeros2");

    // Random tables on a random instance.
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < 5; k++) tbl[k] = 16'($urandom);
      do_sweep(($urandom_range(0, 1) == 0) ? 0 : 2, 1'($urandom_range(0, 1)), $sformatf("rand%0d", it));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
